t07_load_store_unit: RTL and testbench

Memory-access stage of the team_07 CPU: turns the core's load/store requests into single-beat transactions on the data-memory bus, stalls the core while a transaction is outstanding, and returns the aligned, sign- or zero-extended load value as `memResult` to the write-data select stage. Detects misaligned or illegal accesses and bus timeouts, and reports them to the control unit without issuing or completing a bus write.

---
 rtl/t07_lsu_pkg.sv | 54 +++++
 rtl/t07_load_formatter.sv | 34 +++
 rtl/t07_load_store_unit.sv | 128 ++++++++++++
 tb/tb_t07_load_store_unit.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/t07_lsu_pkg.sv
// Shared types, funct3 encodings and lane helpers for the team_07 load/store unit.
package t07_lsu_pkg;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_WAIT = 2'd1,
        LSU_DONE = 2'd2,
        LSU_ERR  = 2'd3
    } lsu_state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Byte-lane strobes; loads use the same pattern as the equivalent store.
    function automatic logic [3:0] lane_sel(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] sel;
        case (f3[1:0])
            2'b00:   sel = 4'b0001 << off;
            2'b01:   sel = off[1] ? 4'b1100 : 4'b0011;
            default: sel = 4'b1111;
        endcase
        return sel;
    endfunction

    // Legal size/sign encoding for the direction, and naturally aligned.
    function automatic logic access_ok(input logic [2:0] f3, input logic [1:0] off,
                                       input logic is_store);
        logic ok;
        case (f3)
            F3_LB:   ok = 1'b1;
            F3_LBU:  ok = !is_store;
            F3_LH:   ok = !off[0];
            F3_LHU:  ok = !off[0] && !is_store;
            F3_LW:   ok = (off == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Store data replicated across every lane the access size can hit.
    function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] sd);
        logic [31:0] wd;
        case (f3[1:0])
            2'b00:   wd = {4{sd[7:0]}};
            2'b01:   wd = {2{sd[15:0]}};
            default: wd = sd;
        endcase
        return wd;
    endfunction

endpackage

// File: rtl/t07_load_formatter.sv
// Extracts the addressed byte/halfword from a bus word and sign/zero extends it.
module t07_load_formatter
    import t07_lsu_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  off_i,
    output logic [31:0] result_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane pick by byte offset, then extension by access type.
    always_comb begin
        byte_sel = rdata_i[7:0];
        case (off_i)
            2'd0: byte_sel = rdata_i[7:0];
            2'd1: byte_sel = rdata_i[15:8];
            2'd2: byte_sel = rdata_i[23:16];
            2'd3: byte_sel = rdata_i[31:24];
            default: byte_sel = rdata_i[7:0];
        endcase
        half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (funct3_i)
            F3_LB:   result_o = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  result_o = {24'd0, byte_sel};
            F3_LH:   result_o = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  result_o = {16'd0, half_sel};
            default: result_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/t07_load_store_unit.sv
// Memory-access stage: single-beat bus transactions, core stall, load formatting,
// access-fault and bus-timeout reporting.
module t07_load_store_unit
    import t07_lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] storeData,
    input  logic        busAck,
    input  logic [31:0] busRdata,
    output logic        busReq,
    output logic        busWen,
    output logic [31:0] busAddr,
    output logic [31:0] busWdata,
    output logic [3:0]  busSel,
    output logic [31:0] memResult,
    output logic        freeze,
    output logic        accessErr,
    output logic        busTimeout
);

    localparam int unsigned   CW      = $clog2(TIMEOUT + 1);
    // Last WAIT cycle index (counter starts at 0 on the first WAIT cycle).
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    lsu_state_t  state_q;
    logic [CW-1:0] cnt_q;
    logic        busReq_q, busWen_q, accessErr_q, busTimeout_q;
    logic [31:0] busAddr_q, busWdata_q, memResult_q;
    logic [3:0]  busSel_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;

    logic        req_d, store_d, ok_d;
    logic [31:0] fmt_d;

    // A load wins when both requests are raised together.
    assign req_d   = memRead | memWrite;
    assign store_d = memWrite & ~memRead;
    assign ok_d    = access_ok(funct3, addr[1:0], store_d);

    t07_load_formatter u_fmt (
        .rdata_i  (busRdata),
        .funct3_i (f3_q),
        .off_i    (off_q),
        .result_o (fmt_d)
    );

    // Control FSM with request latches, timeout counter and registered outputs.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q      <= LSU_IDLE;
            cnt_q        <= '0;
            busReq_q     <= 1'b0;
            busWen_q     <= 1'b0;
            busAddr_q    <= 32'd0;
            busWdata_q   <= 32'd0;
            busSel_q     <= 4'b0000;
            memResult_q  <= 32'd0;
            accessErr_q  <= 1'b0;
            busTimeout_q <= 1'b0;
            f3_q         <= 3'd0;
            off_q        <= 2'd0;
        end else begin
            accessErr_q  <= 1'b0;
            busTimeout_q <= 1'b0;
            case (state_q)
                LSU_IDLE: begin
                    if (req_d) begin
                        if (ok_d) begin
                            state_q    <= LSU_WAIT;
                            cnt_q      <= '0;
                            busReq_q   <= 1'b1;
                            busWen_q   <= store_d;
                            busAddr_q  <= {addr[31:2], 2'b00};
                            busSel_q   <= lane_sel(funct3, addr[1:0]);
                            busWdata_q <= store_lanes(funct3, storeData);
                            f3_q       <= funct3;
                            off_q      <= addr[1:0];
                        end else begin
                            state_q     <= LSU_ERR;
                            accessErr_q <= 1'b1;
                        end
                    end
                end
                LSU_WAIT: begin
                    // Ack is checked first so it beats a same-cycle timeout.
                    if (busAck) begin
                        if (!busWen_q) memResult_q <= fmt_d;
                        state_q  <= LSU_DONE;
                        busReq_q <= 1'b0;
                        busWen_q <= 1'b0;
                    end else if (cnt_q == TO_LAST) begin
                        state_q      <= LSU_DONE;
                        busReq_q     <= 1'b0;
                        busWen_q     <= 1'b0;
                        busTimeout_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                LSU_DONE: state_q <= LSU_IDLE;
                LSU_ERR:  state_q <= LSU_IDLE;
                default:  state_q <= LSU_IDLE;
            endcase
        end
    end

    // Stall is combinational so the request cycle itself holds the core;
    // gated by reset so an abandoned transaction releases the core at once.
    assign freeze = nrst & (((state_q == LSU_IDLE) & req_d) | (state_q == LSU_WAIT));

    assign busReq     = busReq_q;
    assign busWen     = busWen_q;
    assign busAddr    = busAddr_q;
    assign busWdata   = busWdata_q;
    assign busSel     = busSel_q;
    assign memResult  = memResult_q;
    assign accessErr  = accessErr_q;
    assign busTimeout = busTimeout_q;

endmodule

// File: tb/tb_t07_load_store_unit.sv
// Scoreboard bench for the load/store unit (TIMEOUT = 4).
module tb_t07_load_store_unit;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        memRead = 1'b0, memWrite = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] addr = 32'd0, storeData = 32'd0;
    logic        busAck = 1'b0;
    logic [31:0] busRdata = 32'd0;
    logic        busReq, busWen, freeze, accessErr, busTimeout;
    logic [31:0] busAddr, busWdata, memResult;
    logic [3:0]  busSel;

    typedef struct {
        logic [31:0] res;
        logic        to;
    } sb_ent_t;

    sb_ent_t     sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_load = 32'd0;
    logic        prev_req = 1'b0;

    t07_load_store_unit #(.TIMEOUT(4)) dut (
        .clk(clk), .nrst(nrst), .memRead(memRead), .memWrite(memWrite),
        .funct3(funct3), .addr(addr), .storeData(storeData),
        .busAck(busAck), .busRdata(busRdata), .busReq(busReq), .busWen(busWen),
        .busAddr(busAddr), .busWdata(busWdata), .busSel(busSel),
        .memResult(memResult), .freeze(freeze), .accessErr(accessErr),
        .busTimeout(busTimeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // DONE cycle is the first negedge after busReq falls with reset released.
    always @(negedge clk) begin
        if (nrst && prev_req && !busReq) begin
            if (sb.size() == 0) begin
                chk("sb_empty", 32'd1, 32'd0);
            end else begin
                chk("memResult", memResult, sb[0].res);
                chk("busTimeout", {31'd0, busTimeout}, {31'd0, sb[0].to});
                void'(sb.pop_front());
            end
        end
        prev_req <= busReq;
    end

    // ack_at: WAIT cycle (1-based) carrying busAck, 0 = never acked.
    task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] sd, input int ack_at,
                          input logic [31:0] rdata, input logic [3:0] e_sel,
                          input logic [31:0] e_wdata, input bit e_err,
                          input logic [31:0] e_res, input int e_frz);
        int      frz, waits;
        sb_ent_t ent;
        memRead = rd; memWrite = wr; funct3 = f3; addr = a; storeData = sd;
        #1;
        frz = freeze ? 1 : 0;
        chk("req_idle", {31'd0, busReq}, 32'd0);
        if (e_err) begin
            step();
            chk("err_pulse", {31'd0, accessErr}, 32'd1);
            chk("err_req", {31'd0, busReq}, 32'd0);
            if (freeze) frz++;
            memRead = 1'b0; memWrite = 1'b0;
            step();
            chk("err_clr", {31'd0, accessErr}, 32'd0);
            chk("err_res", memResult, last_load);
        end else begin
            ent.res = (rd && ack_at != 0) ? e_res : last_load;
            ent.to  = (ack_at == 0);
            sb.push_back(ent);
            if (rd && ack_at != 0) last_load = e_res;
            waits = 0;
            step();
            while (busReq === 1'b1 && waits < 8) begin
                waits++;
                if (freeze) frz++;
                if (waits == 1) begin
                    chk("busAddr", busAddr, {a[31:2], 2'b00});
                    chk("busSel", {28'd0, busSel}, {28'd0, e_sel});
                    chk("busWen", {31'd0, busWen}, {31'd0, (wr & ~rd)});
                    if (wr && !rd) chk("busWdata", busWdata, e_wdata);
                end
                if (waits == ack_at) begin
                    busAck = 1'b1; busRdata = rdata;
                end
                step();
                busAck = 1'b0; busRdata = $urandom();
            end
            chk("wait_cycles", 32'(waits), (ack_at == 0) ? 32'd4 : 32'(ack_at));
            if (freeze) frz++;
            memRead = 1'b0; memWrite = 1'b0;
            step();
            chk("to_clr", {31'd0, busTimeout}, 32'd0);
        end
        chk("frz_cycles", 32'(frz), 32'(e_frz));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        #2;
        chk("rst_req", {31'd0, busReq}, 32'd0);
        chk("rst_res", memResult, 32'd0);
        chk("rst_sel", {28'd0, busSel}, 32'd0);
        chk("rst_misc", {27'd0, busWen, freeze, accessErr, busTimeout, 1'b0}, 32'd0);
        chk("rst_bus", busAddr | busWdata, 32'd0);
        step();
        nrst = 1'b1;
        step();

        //      rd wr f3      addr          sd            ack rdata          sel     wdata         err res            frz
        access(1, 0, 3'b010, 32'h0000_1000, 32'h0,        1, 32'hCAFE_BABE, 4'b1111, 32'h0,        0, 32'hCAFE_BABE, 2);
        access(1, 0, 3'b000, 32'h0000_2003, 32'h0,        2, 32'h80FF_0000, 4'b1000, 32'h0,        0, 32'hFFFF_FF80, 3);
        access(1, 0, 3'b100, 32'h0000_2003, 32'h0,        1, 32'h80FF_0000, 4'b1000, 32'h0,        0, 32'h0000_0080, 2);
        access(0, 1, 3'b001, 32'h0000_3002, 32'h1234_ABCD, 1, 32'h0,       4'b1100, 32'hABCD_ABCD, 0, 32'h0,        2);
        access(1, 0, 3'b010, 32'h0000_4001, 32'h0,        1, 32'h0,        4'b0000, 32'h0,        1, 32'h0,        1);
        access(1, 0, 3'b011, 32'h0000_4000, 32'h0,        1, 32'h0,        4'b0000, 32'h0,        1, 32'h0,        1);
        access(0, 1, 3'b100, 32'h0000_4000, 32'h55,       1, 32'h0,        4'b0000, 32'h0,        1, 32'h0,        1);
        access(0, 1, 3'b001, 32'h0000_4003, 32'h55,       1, 32'h0,        4'b0000, 32'h0,        1, 32'h0,        1);
        access(1, 0, 3'b010, 32'h0000_8000, 32'h0,        0, 32'h0,        4'b1111, 32'h0,        0, 32'h0,        5);
        access(1, 0, 3'b010, 32'h0000_8004, 32'h0,        4, 32'h1357_9BDF, 4'b1111, 32'h0,        0, 32'h1357_9BDF, 5);
        access(1, 0, 3'b001, 32'h0000_5002, 32'h0,        1, 32'h8001_7FFF, 4'b1100, 32'h0,        0, 32'hFFFF_8001, 2);
        access(1, 0, 3'b101, 32'h0000_5000, 32'h0,        1, 32'h8001_7FFF, 4'b0011, 32'h0,        0, 32'h0000_7FFF, 2);
        access(0, 1, 3'b000, 32'h0000_6001, 32'h0000_00A5, 3, 32'h0,       4'b0010, 32'hA5A5_A5A5, 0, 32'h0,        4);
        access(0, 1, 3'b010, 32'h0000_7000, 32'hDEAD_BEEF, 1, 32'h0,       4'b1111, 32'hDEAD_BEEF, 0, 32'h0,        2);
        access(1, 1, 3'b100, 32'h0000_2003, 32'h1111_2222, 1, 32'h80FF_0000, 4'b1000, 32'h0,      0, 32'h0000_0080, 2);

        // Ack with no transaction in flight is ignored.
        busAck = 1'b1; busRdata = 32'hFFFF_FFFF;
        step(); step();
        chk("stray_req", {31'd0, busReq}, 32'd0);
        chk("stray_res", memResult, last_load);
        busAck = 1'b0;

        // Reset in the middle of WAIT abandons the access.
        memRead = 1'b1; funct3 = 3'b010; addr = 32'h0000_9000;
        step();
        chk("mid_req", {31'd0, busReq}, 32'd1);
        #2 nrst = 1'b0;
        #1;
        chk("rst_async_req", {31'd0, busReq}, 32'd0);
        chk("rst_async_frz", {31'd0, freeze}, 32'd0);
        memRead = 1'b0;
        step();
        nrst = 1'b1;
        #1;
        chk("post_rst_res", memResult, 32'd0);
        chk("post_rst_err", {30'd0, accessErr, busTimeout}, 32'd0);
        last_load = 32'd0;
        step();
        access(1, 0, 3'b010, 32'h0000_A000, 32'h0, 1, 32'h2468_ACE0, 4'b1111, 32'h0, 0, 32'h2468_ACE0, 2);

        step(); step();
        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
